// File: rtl/xlr8_audio_tone_if.sv
// Control inputs and valid/ready sample stream of xlr8_audio_tone.
// master: the tone source; slave: AVR register side plus the audio packetiser.
interface xlr8_audio_tone_if #(
  parameter int unsigned PHASE_WIDTH = 16
);
  logic [7:0]             volume;
  logic [PHASE_WIDTH-1:0] freq_word;
  logic                   tone_en;
  logic                   sample_ready;
  logic                   sample_valid;
  logic signed [15:0]     sample_l;
  logic signed [15:0]     sample_r;
  logic                   muted;
  logic                   overrun;

  modport master (
    input  volume, freq_word, tone_en, sample_ready,
    output sample_valid, sample_l, sample_r, muted, overrun
  );

  modport slave (
    output volume, freq_word, tone_en, sample_ready,
    input  sample_valid, sample_l, sample_r, muted, overrun
  );
endinterface

// File: rtl/xlr8_audio_tone.sv
// Triangle-wave tone source with ramped gain and a valid/ready sample output.
// Define XLR8_AUDIO_RAMP_EN to ramp gain one step per tick; otherwise gain loads directly.
module xlr8_audio_tone #(
  parameter int unsigned SAMPLE_DIV  = 1,
  parameter int unsigned PHASE_WIDTH = 16
) (
  input  logic              clk_audio,
  input  logic              rst,
  xlr8_audio_tone_if.master aud
);
  localparam int unsigned CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned SMP_W  = 16;
  localparam int unsigned GAIN_W = 8;
  localparam int unsigned PROD_W = SMP_W + GAIN_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_PLAY = 2'd2,
    S_FADE = 2'd3
  } state_t;

  logic [CNT_W-1:0]         r_cnt;
  logic                     w_tick;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [GAIN_W-1:0]        r_gain;
  logic [GAIN_W-1:0]        w_gain_nxt;
  logic [GAIN_W-1:0]        w_gt;
  logic [PHASE_WIDTH-1:0]   r_phase;
  logic [PHASE_WIDTH-1:0]   w_phase_nxt;
  logic                     r_muted;

  logic [SMP_W-1:0]         w_p;
  logic [SMP_W-2:0]         w_u;
  logic signed [SMP_W-1:0]  w_raw;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [SMP_W-1:0]  w_sample;

  logic                     r_valid;
  logic signed [SMP_W-1:0]  r_sample;
  logic                     r_overrun;

  // Sample-rate divider: tick on the last count, then wrap.
  assign w_tick = (r_cnt == CNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk_audio) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // 255 - volume is the bitwise complement for an 8-bit value.
  assign w_gt = ~aud.volume;

  // FSM state, gain and phase registers.
  always_ff @(posedge clk_audio) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gain  <= '0;
      r_phase <= '0;
      r_muted <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_gain  <= w_gain_nxt;
      r_phase <= w_phase_nxt;
      r_muted <= (w_state_nxt == S_IDLE);
    end
  end

  // Next state, gain and phase; everything moves only on a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_gain_nxt  = r_gain;
    w_phase_nxt = r_phase;
    if (w_tick) begin
      w_phase_nxt = r_phase + aud.freq_word;
`ifdef XLR8_AUDIO_RAMP_EN
      if (aud.tone_en) begin
        if (r_gain < w_gt) begin
          w_gain_nxt = r_gain + GAIN_W'(1);
        end else if (r_gain > w_gt) begin
          w_gain_nxt = r_gain - GAIN_W'(1);
        end
        w_state_nxt = (w_gain_nxt == w_gt) ? S_PLAY : S_RAMP;
      end else if (r_state == S_IDLE) begin
        w_gain_nxt  = '0;
        w_phase_nxt = '0;
      end else begin
        w_gain_nxt = (r_gain == '0) ? '0 : (r_gain - GAIN_W'(1));
        if (w_gain_nxt == '0) begin
          w_state_nxt = S_IDLE;
          w_phase_nxt = '0;
        end else begin
          w_state_nxt = S_FADE;
        end
      end
`else
      // Without ramping, RAMP and FADE each occupy exactly one tick.
      case (r_state)
        S_IDLE: begin
          if (aud.tone_en) begin
            w_state_nxt = S_RAMP;
            w_gain_nxt  = w_gt;
          end else begin
            w_gain_nxt  = '0;
            w_phase_nxt = '0;
          end
        end
        S_RAMP, S_PLAY: begin
          if (aud.tone_en) begin
            w_state_nxt = S_PLAY;
            w_gain_nxt  = w_gt;
          end else begin
            w_state_nxt = S_FADE;
            w_gain_nxt  = '0;
          end
        end
        S_FADE: begin
          w_state_nxt = S_IDLE;
          w_gain_nxt  = '0;
          w_phase_nxt = '0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_gain_nxt  = '0;
          w_phase_nxt = '0;
        end
      endcase
`endif
    end
  end

  // Triangle from the top 16 phase bits, scaled by the updated gain.
  always_comb begin
    w_p      = w_phase_nxt[PHASE_WIDTH-1 -: SMP_W];
    w_u      = w_p[SMP_W-1] ? ~w_p[SMP_W-2:0] : w_p[SMP_W-2:0];
    w_raw    = $signed({w_u, 1'b0} ^ 16'h8000);
    w_prod   = PROD_W'(w_raw) * PROD_W'($signed({1'b0, w_gain_nxt}));
    w_sample = (w_state_nxt == S_IDLE) ? '0 : SMP_W'(w_prod >>> 8);
  end

  // Output holding register; a tick always loads, overwriting an unaccepted sample.
  always_ff @(posedge clk_audio) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_sample  <= '0;
      r_overrun <= 1'b0;
    end else if (w_tick) begin
      r_valid  <= 1'b1;
      r_sample <= w_sample;
      if (r_valid && !aud.sample_ready) begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && aud.sample_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign aud.sample_valid = r_valid;
  assign aud.sample_l     = r_sample;
  assign aud.sample_r     = r_sample;
  assign aud.muted        = r_muted;
  assign aud.overrun      = r_overrun;

endmodule

// File: tb/tb_xlr8_audio_tone.sv
// Randomized bench for xlr8_audio_tone against a cycle-level reference model.
// Model follows XLR8_AUDIO_RAMP_EN the same way the design build does.
module tb_xlr8_audio_tone;
  localparam int DIV = 4;
  localparam int PW  = 16;
  localparam int ST_IDLE = 0;
  localparam int ST_RAMP = 1;
  localparam int ST_PLAY = 2;
  localparam int ST_FADE = 3;
`ifdef XLR8_AUDIO_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif

  logic clk_audio = 1'b0;
  logic rst;

  always #5 clk_audio = ~clk_audio;

  xlr8_audio_tone_if #(.PHASE_WIDTH(PW)) aud ();

  xlr8_audio_tone #(
    .SAMPLE_DIV (DIV),
    .PHASE_WIDTH(PW)
  ) dut (
    .clk_audio(clk_audio),
    .rst      (rst),
    .aud      (aud)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int m_st, m_g, m_ph, m_cnt, m_data;
  bit m_valid, m_ovr, m_ticked;
  int q_smp[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tri_smp(input int ph, input int g);
    int p, u, raw;
    p   = ph >> (PW - 16);
    u   = (p < 32768) ? p : 65535 - p;
    raw = 2 * u - 32768;
    return (raw * g) >>> 8;
  endfunction

  function automatic int adv(input int ph, input int fw);
    return (ph + fw) % (1 << PW);
  endfunction

  task automatic model_step(input bit r, input int vol, input int fw, input bit en, input bit rdy);
    int gt, s;
    m_ticked = 1'b0;
    if (r) begin
      m_st = ST_IDLE; m_g = 0; m_ph = 0; m_cnt = 0;
      m_valid = 1'b0; m_data = 0; m_ovr = 1'b0;
      return;
    end
    if (m_cnt != DIV - 1) begin
      m_cnt++;
      if (m_valid && rdy) m_valid = 1'b0;
      return;
    end
    m_cnt    = 0;
    m_ticked = 1'b1;
    gt       = 255 - vol;
`ifdef XLR8_AUDIO_RAMP_EN
    if (en) begin
      if (m_g < gt) m_g++;
      else if (m_g > gt) m_g--;
      m_st = (m_g == gt) ? ST_PLAY : ST_RAMP;
      m_ph = adv(m_ph, fw);
    end else if (m_st == ST_IDLE) begin
      m_g = 0; m_ph = 0;
    end else begin
      if (m_g > 0) m_g--;
      m_ph = adv(m_ph, fw);
      if (m_g == 0) begin m_st = ST_IDLE; m_ph = 0; end
      else m_st = ST_FADE;
    end
`else
    if (m_st == ST_FADE) begin
      m_st = ST_IDLE; m_g = 0; m_ph = 0;
    end else if (m_st == ST_IDLE && !en) begin
      m_g = 0; m_ph = 0;
    end else begin
      m_ph = adv(m_ph, fw);
      if (!en) begin m_st = ST_FADE; m_g = 0; end
      else begin m_st = (m_st == ST_IDLE) ? ST_RAMP : ST_PLAY; m_g = gt; end
    end
`endif
    s = (m_st == ST_IDLE) ? 0 : tri_smp(m_ph, m_g);
    if (m_valid && !rdy) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_data  = s;
  endtask

  // One clock: model sees the inputs present at the edge, outputs checked 1 time unit later.
  task automatic cyc();
    bit r, en, rdy;
    int vol, fw;
    r = rst; en = aud.tone_en; rdy = aud.sample_ready;
    vol = int'(aud.volume); fw = int'(aud.freq_word);
    @(posedge clk_audio);
    model_step(r, vol, fw, en, rdy);
    #1;
    chk("valid",   int'(aud.sample_valid), int'(m_valid));
    chk("sample_l", int'(aud.sample_l), m_data);
    chk("sample_r", int'(aud.sample_r), m_data);
    chk("muted",   int'(aud.muted), int'(m_st == ST_IDLE));
    chk("overrun", int'(aud.overrun), int'(m_ovr));
    if (m_ticked) q_smp.push_back(int'(aud.sample_l));
  endtask

  task automatic run_ticks(input int n);
    repeat (n * DIV) cyc();
  endtask

  initial begin
    int mx, mn, n_pk, n_mn, fade_at;
    rst = 1'b1;
    aud.volume = 8'd0;
    aud.freq_word = '0;
    aud.tone_en = 1'b0;
    aud.sample_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_muted", int'(aud.muted), 1);
    chk("rst_valid", int'(aud.sample_valid), 0);
    chk("rst_sample", int'(aud.sample_l), 0);
    chk("rst_overrun", int'(aud.overrun), 0);

    // Disabled tone: every tick yields 0.
    rst = 1'b0;
    q_smp.delete();
    run_ticks(4);
    for (int i = 0; i < 4; i++) chk("idle_sample", q_smp[i], 0);

    // Ramp up at full volume with constant phase (raw = -32768).
    q_smp.delete();
    aud.tone_en = 1'b1;
    run_ticks(255);
    chk("ramp_first", q_smp[0], RAMP_ON ? -128 : -32640);
    chk("ramp_last", q_smp[254], -32640);
    chk("ramp_unmuted", int'(aud.muted), 0);

    // Volume step while playing.
    q_smp.delete();
    aud.volume = 8'd128;
    run_ticks(1);
    chk("vol_step", q_smp[0], RAMP_ON ? -32512 : -16256);
    aud.volume = 8'd0;
    run_ticks(130);

    // Waveform at full gain: period 32 ticks, one peak and one trough per period.
    q_smp.delete();
    aud.freq_word = 16'h0800;
    run_ticks(64);
    mx = -40000; mn = 40000; n_pk = 0; n_mn = 0;
    foreach (q_smp[i]) begin
      if (q_smp[i] > mx) mx = q_smp[i];
      if (q_smp[i] < mn) mn = q_smp[i];
    end
    foreach (q_smp[i]) begin
      if (q_smp[i] == 32638) n_pk++;
      if (q_smp[i] == -32640) n_mn++;
    end
    chk("wave_peak", mx, 32638);
    chk("wave_trough", mn, -32640);
    chk("wave_peak_count", n_pk, 2);
    chk("wave_trough_count", n_mn, 2);

    // Fade out from full gain.
    aud.tone_en = 1'b0;
    fade_at = 0;
    for (int k = 1; k <= 300; k++) begin
      run_ticks(1);
      if (aud.muted) begin
        fade_at = k;
        break;
      end
    end
    chk("fade_ticks", fade_at, RAMP_ON ? 255 : 2);

    // Handshake and overrun.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    aud.tone_en = 1'b1;
    run_ticks(4);
    aud.sample_ready = 1'b1;
    repeat (2) cyc();
    aud.sample_ready = 1'b0;
    repeat (5) cyc();
    chk("ovr_first_tick", int'(aud.overrun), 0);
    cyc();
    chk("ovr_second_tick", int'(aud.overrun), 1);
    chk("ovr_valid_held", int'(aud.sample_valid), 1);
    repeat (4) cyc();
    aud.sample_ready = 1'b1;
    cyc();
    chk("ready_drop", int'(aud.sample_valid), 0);
    chk("ovr_sticky", int'(aud.overrun), 1);

    // Randomized traffic with occasional resets.
    repeat (4000) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 49) == 0) aud.volume = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) aud.freq_word = 16'($urandom);
      if ($urandom_range(0, 299) == 0) aud.tone_en = ~aud.tone_en;
      aud.sample_ready = ($urandom_range(0, 7) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/xlr8_audio_tone.md
# xlr8_audio_tone

Audio sample source feeding the HDMI audio packetiser in the `clk_audio` domain. It generates a triangle-wave tone from a phase accumulator and scales it by the attenuation value held in the AVR-written volume register. Gain changes are ramped to avoid zipper noise. Samples are presented on a valid/ready handshake.

## Interface
- `SAMPLE_DIV`, 1: number of `clk_audio` cycles per sample tick (≥1).
- `PHASE_WIDTH`, 16: phase accumulator and `freq_word` width (≥16).
- `clk_audio`  in  1: audio clock; all logic rises on it. One clock only.
- `rst`  in  1: synchronous, active-high reset.
- `volume`  in  8: attenuation; 0 = loudest, 255 = quietest. Sampled at every tick.
- `freq_word`  in  PHASE_WIDTH: phase increment per tick. Sampled at every tick.
- `tone_en`  in  1: 1 = play, 0 = ramp down and mute.
- `sample_ready`  in  1: downstream accepts the sample this cycle.
- `sample_valid`  out  1: `sample_l`/`sample_r` hold a sample.
- `sample_l`, `sample_r`  out  16: signed PCM; both carry the same value.
- `muted`  out  1: high in state IDLE.
- `overrun`  out  1: sticky; a tick occurred while a sample was still pending.

## Operation
- Tick counter counts 0..SAMPLE_DIV-1. `tick` is high when the count is SAMPLE_DIV-1. The counter wraps to 0 on that cycle.
- Target gain `gt = 255 - volume` (8-bit). Current gain `g` is 8-bit, reset 0.
- State machine, reset state IDLE:
  - IDLE: `g=0`, phase=0. Goes to RAMP when `tone_en=1` at a tick.
  - RAMP: on each tick, `g` moves one step toward `gt` (+1 or −1). Goes to PLAY when `g==gt` after the step. Goes to FADE if `tone_en=0`.
  - PLAY: `g` follows `gt` by ramping. If `gt` changes, re-enter RAMP. Goes to FADE if `tone_en=0`.
  - FADE: on each tick, `g` steps −1. Goes to IDLE when `g==0` after the step. Returns to RAMP if `tone_en=1`.
- Phase update at each tick outside IDLE: `phase <= phase + freq_word`, modulo 2^PHASE_WIDTH.
- Triangle from top 16 phase bits `p`:
  - `u = p[15] ? ~p[14:0] : p[14:0]`
  - `raw = {u,1'b0} ^ 16'h8000`, interpreted as signed. Range −32768..+32766.
- Output: `s = (raw * g) >>> 8`. Signed 16×9 product with `g` zero-extended; arithmetic shift; take the low 16 bits. This cannot overflow.
- Every tick produces one sample computed from the updated `g` and phase. In IDLE the sample is 0.
- Handshake:
  - `sample_valid` rises the cycle after the tick.
  - It holds, with data stable, until a cycle where `sample_valid && sample_ready`. It drops the next cycle unless a new tick loads a fresh sample in that same cycle.
- Overrun: a tick while `sample_valid=1` and `sample_ready=0`.
  - The new sample replaces the pending one; `sample_valid` stays high.
  - `overrun` sets and stays set until `rst`.
- `tone_en` and `volume` changes between ticks take effect only at the next tick.

## Timing
- Reset values: `sample_valid=0`, `sample_l=sample_r=0`, `muted=1`, `overrun=0`. Also tick counter 0, phase 0, `g=0`, state IDLE.
- Latency: one cycle from tick to `sample_valid`/data. There are no combinational paths from inputs to outputs.
- Throughput: one sample per SAMPLE_DIV cycles. With SAMPLE_DIV=1, `sample_ready` must be held high to avoid overrun.
- Full ramp 0→255 takes 255 ticks.
- `rst` mid-ramp or with a pending sample: all state returns to reset values on the next edge, and the pending sample is discarded.

## Configuration
- `XLR8_AUDIO_RAMP_EN` defined: gain ramps as described above.
- Not defined:
  - `g` loads `gt` directly at each tick; no ramp.
  - RAMP and FADE each last exactly one tick: RAMP→PLAY, FADE→IDLE.
  - All other behaviour is unchanged.

## Test plan
- Reset: assert `rst` for 3 cycles. Required: `muted=1`, `sample_valid=0`, samples 0, `overrun=0`. With `tone_en=0` and `sample_ready=1`, every tick yields sample 0.
- Ramp (macro on): SAMPLE_DIV=4, `volume=0`, `freq_word=0`, `tone_en=1`.
  - `raw=-32768`; the first sample is −128 (g=1).
  - PLAY is reached after 255 ticks with sample −32640.
- Waveform: ramp complete with `volume=0` and `freq_word=16'h0800`. Required: samples repeat with period 32 ticks. Peak is `(32766*255)>>>8` = 32638.
- Fade: `tone_en` dropped in PLAY with `volume=0`. Required: `g` decrements 1 per tick; IDLE and `muted=1` after 255 ticks; phase becomes 0.
- Handshake/overrun: SAMPLE_DIV=4, `sample_ready=0` for 10 cycles.
  - Required: `sample_valid` stays high with data replaced at each tick; `overrun=1` after the second tick.
  - Then `sample_ready=1` for one cycle: `sample_valid` drops the next cycle.
- Macro off: `volume` steps 0→128 in PLAY. Required: `g` becomes 127 at the very next tick, and the output sample reflects gain 127 one cycle later.
